// File: rtl/nibble_serial_add16.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add16 (with helper rca4)
// Brief    : 16-bit adder that reuses one 4-bit ripple-carry adder over four
//            cycles, LSB nibble first, with registered sum/carry/overflow.
// Revision : 1.0 - initial release
// ============================================================================

module rca4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] w_c;

   assign w_c[0] = ci;

   generate
      for (genvar i = 0; i < 4; i++) begin : g_bit
         assign s[i]     = a[i] ^ b[i] ^ w_c[i];
         assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
      end
   endgenerate

   assign co = w_c[4];
endmodule

module nibble_serial_add16 (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        ci,
   output logic [15:0] s,
   output logic        co,
   output logic        ovf,
   output logic        busy,
   output logic        done
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic [15:0] r_a;
   logic [15:0] r_b;
   logic [15:0] r_acc;
   logic [1:0]  r_k;
   logic        r_carry;
   logic [15:0] r_s;
   logic        r_co;
   logic        r_ovf;
   logic        r_busy;
   logic        r_done;

   logic [3:0]  w_nib_idx;
   logic [3:0]  w_rca_s;
   logic        w_rca_co;
   logic [15:0] w_acc_next;

   assign w_nib_idx = {r_k, 2'b00};

   rca4 u_rca4 (
      .a  (r_a[w_nib_idx +: 4]),
      .b  (r_b[w_nib_idx +: 4]),
      .ci (r_carry),
      .s  (w_rca_s),
      .co (w_rca_co)
   );

   // Accumulator with the current nibble merged in, so the final edge can
   // publish the complete sum without a second cycle.
   always_comb begin
      w_acc_next                  = r_acc;
      w_acc_next[w_nib_idx +: 4]  = w_rca_s;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (start)        w_next_state = ST_ADD;
         ST_ADD:  if (r_k == 2'd3)  w_next_state = ST_DONE;
         ST_DONE:                   w_next_state = ST_IDLE;
         default:                   w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_a     <= 16'h0000;
         r_b     <= 16'h0000;
         r_acc   <= 16'h0000;
         r_k     <= 2'd0;
         r_carry <= 1'b0;
         r_s     <= 16'h0000;
         r_co    <= 1'b0;
         r_ovf   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state == ST_ADD);
         r_done  <= (w_next_state == ST_DONE);
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_k     <= 2'd0;
                  r_carry <= ci;
               end
            end
            ST_ADD: begin
               r_acc   <= w_acc_next;
               r_carry <= w_rca_co;
               r_k     <= r_k + 2'd1;
               if (r_k == 2'd3) begin
                  r_s   <= w_acc_next;
                  r_co  <= w_rca_co;
                  r_ovf <= (r_a[15] == r_b[15]) && (w_acc_next[15] != r_a[15]);
               end
            end
            default: ;
         endcase
      end
   end

   assign s    = r_s;
   assign co   = r_co;
   assign ovf  = r_ovf;
   assign busy = r_busy;
   assign done = r_done;
endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_add16.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_add16
// Brief    : Random and directed stimulus against a latency/arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_nibble_serial_add16;
   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        ci;
   logic [15:0] s;
   logic        co;
   logic        ovf;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;
   int n_busy = 0;
   int n_done = 0;
   bit chk_en = 1'b0;

   // Reference model: plain 17-bit arithmetic, result due five edges after
   // acceptance, busy for the four edges in between.
   int          ph = 0;
   logic [15:0] pa, pb;
   logic        pci;
   logic [16:0] sum17;
   logic [15:0] m_s = 16'h0;
   logic        m_co = 1'b0;
   logic        m_ovf = 1'b0;

   always #5 clk = ~clk;

   nibble_serial_add16 dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .ci    (ci),
      .s     (s),
      .co    (co),
      .ovf   (ovf),
      .busy  (busy),
      .done  (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         ph = 0; m_s = 16'h0; m_co = 1'b0; m_ovf = 1'b0;
      end else if (ph == 0) begin
         if (start) begin
            pa = a; pb = b; pci = ci; ph = 1;
         end
      end else if (ph == 4) begin
         sum17 = {1'b0, pa} + {1'b0, pb} + {16'h0, pci};
         m_s   = sum17[15:0];
         m_co  = sum17[16];
         m_ovf = (pa[15] == pb[15]) && (sum17[15] != pa[15]);
         ph    = 5;
      end else if (ph == 5) begin
         ph = 0;
      end else begin
         ph = ph + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("s",    {16'h0, s},    {16'h0, m_s});
         check("co",   {31'h0, co},   {31'h0, m_co});
         check("ovf",  {31'h0, ovf},  {31'h0, m_ovf});
         check("busy", {31'h0, busy}, {31'h0, (ph >= 1 && ph <= 4)});
         check("done", {31'h0, done}, {31'h0, (ph == 5)});
         if (busy) n_busy++;
         if (done) n_done++;
      end
   end

   // One operation; operands are scrambled during ADD, optionally with
   // start re-asserted, and optionally compared against literal results.
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tci,
                        input bit junk, input bit lit,
                        input logic [15:0] es, input logic eco, input logic eovf);
      int  b0, d0;
      bit  seen;
      @(negedge clk);
      b0 = n_busy; d0 = n_done;
      start = 1'b1; a = ta; b = tb_; ci = tci;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         start = junk;
         a     = junk ? 16'hFFFF : 16'($urandom);
         b     = 16'($urandom);
         ci    = 1'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) begin seen = 1'b1; break; end
      end
      if (!seen) check("done_timeout", 32'd0, 32'd1);
      if (lit) begin
         check("lit_s",     {16'h0, s},    {16'h0, es});
         check("lit_co",    {31'h0, co},   {31'h0, eco});
         check("lit_ovf",   {31'h0, ovf},  {31'h0, eovf});
         check("model_s",   {16'h0, m_s},  {16'h0, es});
         check("model_ovf", {31'h0, m_ovf},{31'h0, eovf});
      end
      @(negedge clk);
      if (lit) begin
         check("busy_cycles", n_busy - b0, 32'd4);
         check("done_pulses", n_done - d0, 32'd1);
      end
   endtask

   initial begin
      int d0;
      reset = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; ci = 1'b0;
      repeat (3) @(negedge clk);
      reset  = 1'b0;
      chk_en = 1'b1;
      check("rst_s",    {16'h0, s}, 32'h0);
      check("rst_flags", {28'h0, co, ovf, busy, done}, 32'h0);

      do_op(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
      do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
      do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
      do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
      do_op(16'h1111, 16'h2222, 1'b0, 1'b1, 1'b1, 16'h3333, 1'b0, 1'b0);

      // Abort with reset on the second ADD edge.
      @(negedge clk);
      start = 1'b1; a = 16'hABCD; b = 16'h1357; ci = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      d0 = n_done;
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_s",    {16'h0, s},    32'h0);
      repeat (8) @(negedge clk);
      check("abort_no_done", n_done - d0, 32'd0);
      do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);

      for (int n = 0; n < 150; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0,
               16'h0, 1'b0, 1'b0);
      end

      repeat (2) @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, limit 500000 reached");
      $fatal(1, "watchdog");
   end
endmodule

`default_nettype wire

// File: doc/nibble_serial_add16.md
NIBBLE_SERIAL_ADD16 -- requirements
Module: nibble_serial_add16

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 The block SHALL have the following ports:
- clk    input   1   rising-edge clock
- reset  input   1   synchronous active-high reset
- start  input   1   request to begin an addition; sampled only in IDLE
- a      input   16  operand A; captured on the accepting edge
- b      input   16  operand B; captured on the accepting edge
- ci     input   1   carry-in; captured on the accepting edge
- s      output  16  registered sum of the last completed operation
- co     output  1   registered carry-out of bit 15
- ovf    output  1   registered two's-complement overflow
- busy   output  1   high while an operation is in progress
- done   output  1   one-cycle completion pulse
REQ-003 The block SHALL instantiate rca4 (4-bit sum s, carry co = a + b + ci) as its only adder and SHALL NOT infer any wider adder.

Function
REQ-004 The FSM SHALL have exactly three states, IDLE, ADD and DONE, each registered on the rising edge of clk.
REQ-005 IDLE transitions:
- start = 1 at edge N: the block captures a, b and ci into internal registers, loads the nibble counter with 0 and the running carry with ci, and moves to ADD.
- start = 0: the block stays in IDLE.
REQ-006 The rca4 inputs in ADD SHALL be captured A[4k+3:4k], captured B[4k+3:4k] and the running carry, where k is the nibble counter (0..3).
REQ-007 Each ADD edge SHALL perform the following updates:
- rca4 s is written into accumulator nibble k.
- The running carry takes rca4 co.
- k increments.
REQ-008 ADD SHALL process nibbles LSB first at edges N+1 to N+4; at the k = 3 edge the state moves to DONE and the counter wraps to 0.
REQ-009 On the k = 3 edge, s SHALL load the full accumulator and co SHALL load rca4 co.
REQ-010 On the k = 3 edge, ovf SHALL load (A[15] == B[15]) && (sum[15] != A[15]).
REQ-011 s, co and ovf SHALL hold their previous values at all other times; partial sums are never visible on s.
REQ-012 busy SHALL be 1 exactly when the state is ADD and SHALL be a registered output.
REQ-013 done SHALL be 1 exactly when the state is DONE, i.e. for the single cycle after edge N+4; DONE always returns to IDLE on the next edge.
REQ-014 Total latency SHALL be: start accepted at edge N, result valid and done = 1 after edge N+4.
REQ-015 The block SHALL accept a new start no earlier than edge N+5, when it is back in IDLE.
REQ-016 start SHALL be ignored in ADD and DONE, with no effect on captured operands, counter or outputs.
REQ-017 Operand changes on a, b or ci after the accepting edge SHALL NOT affect the in-flight result.
REQ-018 Arithmetic SHALL be unsigned modulo 2^16 for s, with co the 17th sum bit; ovf is meaningful only under a signed interpretation.

Reset
REQ-019 On any rising edge of clk with reset = 1, the following SHALL hold:
- The state is IDLE.
- The counter, running carry, captured operands and accumulator are 0.
- s = 0x0000, co = 0, ovf = 0, busy = 0, done = 0.
REQ-020 Reset SHALL take priority over start and over every state transition.
REQ-021 Reset asserted mid-ADD SHALL abort the operation; no done pulse is produced for the aborted operation.

Verification
REQ-022 After reset, a bench SHALL confirm all outputs are 0; start with a = 0x0000, b = 0x0000, ci = 0 SHALL give s = 0x0000, co = 0, ovf = 0, done high for one cycle after edge N+4, and busy high for exactly 4 cycles.
REQ-023 a = 0x00FF, b = 0x0001, ci = 0 SHALL give s = 0x0100, co = 0, ovf = 0 (inter-nibble carry chain).
REQ-024 a = 0x1234, b = 0x4321, ci = 1 SHALL give s = 0x5556, co = 0, ovf = 0.
REQ-025 The following carry and overflow boundaries SHALL be covered:
- 0xFFFF + 0x0001 (ci = 0) gives s = 0x0000, co = 1, ovf = 0.
- 0x7FFF + 0x0001 gives s = 0x8000, co = 0, ovf = 1.
- 0x8000 + 0x8000 gives s = 0x0000, co = 1, ovf = 1.
REQ-026 Start with a = 0x1111, b = 0x2222, then re-assert start with a = 0xFFFF during ADD: the block SHALL give s = 0x3333 with exactly one done pulse.
REQ-027 Reset asserted at edge N+2 of an operation SHALL leave busy = 0, s = 0x0000 and no done pulse; a new start afterwards SHALL complete normally.
